// File: rtl/exec_mem_unit_if.sv
// Bundles the instruction/operand inputs and decode/ALU/memory outputs of exec_mem_unit.
// The master drives opcode and operands. The slave (the execute/memory stage) returns the results.
interface exec_mem_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            opcode;
  logic [1:0]            format;
  logic                  imm_flag;
  logic [DATA_WIDTH-1:0] reg1_data;
  logic [DATA_WIDTH-1:0] reg2_data;
  logic [3:0]            alu_inst;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  branch_taken;
  logic                  write_reg;
  logic                  write_mem;
  logic                  read_mem;
  logic [DATA_WIDTH-1:0] mem_q;

  modport master (
    output opcode, format, imm_flag, reg1_data, reg2_data,
    input  alu_inst, alu_result, branch_taken, write_reg, write_mem, read_mem, mem_q
  );

  modport slave (
    input  opcode, format, imm_flag, reg1_data, reg2_data,
    output alu_inst, alu_result, branch_taken, write_reg, write_mem, read_mem, mem_q
  );
endinterface

// File: rtl/exec_mem_unit.sv
// Execute/memory stage of the 8-bit single-cycle CPU.
// It holds the control decode, the combinational ALU with branch compare, and the synchronous data memory.
module exec_mem_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  exec_mem_unit_if.slave bus
);

  localparam int Depth = 1 << ADDR_WIDTH;

  typedef enum logic [3:0] {
    OpAdd = 4'h0,
    OpSub = 4'h1,
    OpAnd = 4'h2,
    OpOr  = 4'h3,
    OpXor = 4'h4,
    OpNot = 4'h5,
    OpSll = 4'h6,
    OpSrl = 4'h7,
    OpMov = 4'h8,
    OpLi  = 4'h9,
    OpLw  = 4'hA,
    OpSw  = 4'hB,
    OpBeq = 4'hC,
    OpBne = 4'hD,
    OpSlt = 4'hE,
    OpNop = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FmtR = 2'b00,
    FmtI = 2'b01,
    FmtM = 2'b10,
    FmtB = 2'b11
  } format_e;

  opcode_e               op;
  format_e               reqFormat;
  logic                  legal;
  opcode_e               aluInst;
  logic                  writeReg;
  logic                  writeMem;
  logic                  readMem;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  branchTaken;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memArray [Depth];
  logic [DATA_WIDTH-1:0] memData_d;
  logic [DATA_WIDTH-1:0] memData_q;

  assign op      = opcode_e'(bus.opcode);
  assign memAddr = bus.reg1_data[ADDR_WIDTH-1:0];

  // Any opcode whose format or immediate flag does not match its encoding becomes a NOP.
  always_comb begin
    reqFormat = FmtR;
    case (op)
      OpLi:         reqFormat = FmtI;
      OpLw, OpSw:   reqFormat = FmtM;
      OpBeq, OpBne: reqFormat = FmtB;
      default:      reqFormat = FmtR;
    endcase
    legal = (op != OpNop) &&
            (format_e'(bus.format) == reqFormat) &&
            (bus.imm_flag == (op == OpLi));
  end

  always_comb begin
    aluInst  = OpNop;
    writeReg = 1'b0;
    writeMem = 1'b0;
    readMem  = 1'b0;
    if (legal) begin
      case (op)
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot, OpSll, OpSrl, OpSlt: begin
          aluInst  = op;
          writeReg = 1'b1;
        end
        OpMov, OpLi: begin
          writeReg = 1'b1;
        end
        OpLw: begin
          writeReg = 1'b1;
          readMem  = 1'b1;
        end
        OpSw: begin
          writeMem = 1'b1;
        end
        OpBeq, OpBne: begin
          aluInst = op;
        end
        default: begin
          aluInst = OpNop;
        end
      endcase
    end
  end

  // Shifts use only the low three bits of reg2, so amounts stay within one byte lane.
  always_comb begin
    aluResult   = '0;
    branchTaken = 1'b0;
    case (aluInst)
      OpAdd: aluResult = bus.reg1_data + bus.reg2_data;
      OpSub: aluResult = bus.reg1_data - bus.reg2_data;
      OpAnd: aluResult = bus.reg1_data & bus.reg2_data;
      OpOr:  aluResult = bus.reg1_data | bus.reg2_data;
      OpXor: aluResult = bus.reg1_data ^ bus.reg2_data;
      OpNot: aluResult = ~bus.reg1_data;
      OpSll: aluResult = bus.reg1_data << bus.reg2_data[2:0];
      OpSrl: aluResult = bus.reg1_data >> bus.reg2_data[2:0];
      OpSlt: aluResult = {{(DATA_WIDTH-1){1'b0}}, (bus.reg1_data < bus.reg2_data)};
      OpBeq: branchTaken = (bus.reg1_data == bus.reg2_data);
      OpBne: branchTaken = (bus.reg1_data != bus.reg2_data);
      default: begin
        aluResult   = '0;
        branchTaken = 1'b0;
      end
    endcase
  end

  // The storage array has no reset. Reset only blocks writes, so the contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (rst_n && writeMem) begin
      memArray[memAddr] <= bus.reg2_data;
    end
  end

  always_comb begin
    memData_d = memData_q;
    if (readMem) begin
      memData_d = memArray[memAddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memData_q <= '0;
    end else begin
      memData_q <= memData_d;
    end
  end

  assign bus.alu_inst     = aluInst;
  assign bus.alu_result   = aluResult;
  assign bus.branch_taken = branchTaken;
  assign bus.write_reg    = writeReg;
  assign bus.write_mem    = writeMem;
  assign bus.read_mem     = readMem;
  assign bus.mem_q        = memData_q;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus pushes predicted results, a monitor pops and compares.
module tb_exec_mem_unit;

  logic clk;
  logic rst_n;

  exec_mem_unit_if #(.DATA_WIDTH(8)) bus ();

  exec_mem_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [3:0] aluInst;
    logic [7:0] aluResult;
    logic       branch;
    logic       wReg;
    logic       wMem;
    logic       rMem;
    logic [7:0] memQ;
    bit         memKnown;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] memModel [int];
  logic [7:0] expMemQ;
  bit         expMemKnown;
  int         checks;
  int         failures;
  int         stepId;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int id, input logic [7:0] act,
                             input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Results are recomputed from the instruction rules with integer arithmetic.
  function automatic exp_t predict(input int op, input int fmt, input bit imm,
                                   input int a, input int b);
    exp_t e;
    int   req;
    int   eop;
    int   aop;
    int   sh;
    bit   legal;
    e = '{default: 0};
    if (op <= 8 || op == 14) req = 0;
    else if (op == 9) req = 1;
    else if (op == 10 || op == 11) req = 2;
    else req = 3;
    legal = (op != 15) && (fmt == req) && (imm == (op == 9));
    eop = legal ? op : 15;
    e.wReg = (eop <= 10) || (eop == 14);
    e.wMem = (eop == 11);
    e.rMem = (eop == 10);
    aop = ((eop <= 7) || (eop >= 12 && eop <= 14)) ? eop : 15;
    e.aluInst = aop[3:0];
    sh = b % 8;
    case (aop)
      0:  e.aluResult = 8'((a + b) % 256);
      1:  e.aluResult = 8'((a - b + 256) % 256);
      2:  e.aluResult = 8'(a & b);
      3:  e.aluResult = 8'(a | b);
      4:  e.aluResult = 8'(a ^ b);
      5:  e.aluResult = 8'(255 - a);
      6:  e.aluResult = 8'((a * (1 << sh)) % 256);
      7:  e.aluResult = 8'(a / (1 << sh));
      12: e.branch = (a == b);
      13: e.branch = (a != b);
      14: e.aluResult = (a < b) ? 8'd1 : 8'd0;
      default: e.aluResult = 8'd0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input bit rstVal, input logic [3:0] op, input logic [1:0] fmt,
                               input bit imm, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    rst_n         = rstVal;
    bus.opcode    = op;
    bus.format    = fmt;
    bus.imm_flag  = imm;
    bus.reg1_data = a;
    bus.reg2_data = b;
    stepId++;
    e = predict(int'(op), int'(fmt), imm, int'(a), int'(b));
    e.id = stepId;
    if (!rstVal) begin
      expMemQ     = 8'h00;
      expMemKnown = 1'b1;
    end else if (e.rMem) begin
      if (memModel.exists(int'(a))) begin
        expMemQ     = memModel[int'(a)];
        expMemKnown = 1'b1;
      end else begin
        expMemKnown = 1'b0;
      end
    end else if (e.wMem) begin
      memModel[int'(a)] = b;
    end
    e.memQ     = expMemQ;
    e.memKnown = expMemKnown;
    expQ.push_back(e);
    if (!rstVal) begin
      #1;
      checkOutput("async_reset_memq", stepId, bus.mem_q, 8'h00);
    end
  endtask

  // The monitor checks one cycle's outputs just after the edge that consumed them.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("alu_inst", e.id, {4'h0, bus.alu_inst}, {4'h0, e.aluInst});
        checkOutput("alu_result", e.id, bus.alu_result, e.aluResult);
        checkOutput("branch_taken", e.id, {7'h0, bus.branch_taken}, {7'h0, e.branch});
        checkOutput("write_reg", e.id, {7'h0, bus.write_reg}, {7'h0, e.wReg});
        checkOutput("write_mem", e.id, {7'h0, bus.write_mem}, {7'h0, e.wMem});
        checkOutput("read_mem", e.id, {7'h0, bus.read_mem}, {7'h0, e.rMem});
        if (e.memKnown) begin
          checkOutput("mem_q", e.id, bus.mem_q, e.memQ);
        end
      end
    end
  end

  initial begin
    int op;
    int fmt;
    bit imm;
    int a;
    checks        = 0;
    failures      = 0;
    stepId        = 0;
    expMemQ       = 8'h00;
    expMemKnown   = 1'b1;
    rst_n         = 1'b0;
    bus.opcode    = 4'hF;
    bus.format    = 2'b00;
    bus.imm_flag  = 1'b0;
    bus.reg1_data = 8'h00;
    bus.reg2_data = 8'h00;

    applyStimulus(0, 4'hF, 2'b00, 0, 8'h00, 8'h00);
    applyStimulus(1, 4'hF, 2'b00, 0, 8'h00, 8'h00);
    applyStimulus(1, 4'h0, 2'b00, 0, 8'hF0, 8'h20);
    applyStimulus(1, 4'h1, 2'b00, 0, 8'h05, 8'h07);
    applyStimulus(1, 4'h6, 2'b00, 0, 8'h81, 8'h01);
    applyStimulus(1, 4'h7, 2'b00, 0, 8'h81, 8'h03);
    applyStimulus(1, 4'h7, 2'b00, 0, 8'h81, 8'hFB);
    applyStimulus(1, 4'hE, 2'b00, 0, 8'h03, 8'h80);
    applyStimulus(1, 4'hB, 2'b10, 0, 8'h2A, 8'h5C);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'h2A, 8'h00);
    applyStimulus(1, 4'hB, 2'b10, 0, 8'hFF, 8'h11);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'hFF, 8'h00);
    applyStimulus(1, 4'hC, 2'b11, 0, 8'h33, 8'h33);
    applyStimulus(1, 4'hD, 2'b11, 0, 8'h33, 8'h33);
    applyStimulus(1, 4'hD, 2'b11, 0, 8'h33, 8'h34);
    applyStimulus(1, 4'h0, 2'b01, 0, 8'h10, 8'h20);
    applyStimulus(1, 4'hB, 2'b10, 1, 8'h2A, 8'h99);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'h2A, 8'h00);
    applyStimulus(1, 4'h9, 2'b01, 1, 8'h12, 8'h34);
    applyStimulus(1, 4'h8, 2'b00, 0, 8'h12, 8'h34);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'hFF, 8'h00);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'h2A, 8'h00);
    applyStimulus(0, 4'hB, 2'b10, 0, 8'h2A, 8'h77);
    applyStimulus(1, 4'hA, 2'b10, 0, 8'h2A, 8'h00);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 99) < 85) begin
        if (op <= 8 || op == 14) fmt = 0;
        else if (op == 9) fmt = 1;
        else if (op == 10 || op == 11) fmt = 2;
        else fmt = 3;
        imm = (op == 9);
      end else begin
        fmt = $urandom_range(0, 3);
        imm = $urandom_range(0, 1);
      end
      if (op == 10 || op == 11) begin
        a = $urandom_range(0, 8);
        if (a == 8) a = 255;
      end else begin
        a = $urandom_range(0, 255);
      end
      applyStimulus(($urandom_range(0, 49) != 0), 4'(op), 2'(fmt), imm, 8'(a),
                    8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
